// File: rtl/nios2_oci_trace_pkg.sv
// nios2_oci_trace_pkg: shared types and constants for the DCT trace buffer.
// Holds the FSM encoding, the register map and the status word layout.
package nios2_oci_trace_pkg;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_POST    = 2'd1,
        ST_FROZEN  = 2'd2
    } trace_state_e;

    localparam int REG_STATUS  = 0;
    localparam int REG_CONTROL = 1;

    localparam int CTRL_CLEAR_BIT = 0;
    localparam int CTRL_MODE_BIT  = 1;

    localparam int DROP_W          = 8;
    localparam int STAT_ENT_LSB    = 0;
    localparam int STAT_ENT_W      = 11;
    localparam int STAT_WRAP_BIT   = 11;
    localparam int STAT_MODE_BIT   = 12;
    localparam int STAT_STATE_LSB  = 13;
    localparam int STAT_DROPS_LSB  = 15;

    function automatic logic [31:0] pack_status(
        input logic [STAT_ENT_W-1:0] entries,
        input logic                  wrapped,
        input logic                  mode,
        input trace_state_e          st,
        input logic [DROP_W-1:0]     drops
    );
        logic [31:0] s;
        s = '0;
        s[STAT_ENT_LSB +: STAT_ENT_W] = entries;
        s[STAT_WRAP_BIT]              = wrapped;
        s[STAT_MODE_BIT]              = mode;
        s[STAT_STATE_LSB +: 2]        = st;
        s[STAT_DROPS_LSB +: DROP_W]   = drops;
        return s;
    endfunction

endpackage

// File: rtl/nios2_oci_trace_capture_if.sv
// nios2_oci_trace_capture_if: Avalon-MM slave port of the trace buffer.
// Fixed one-cycle read latency, no waitrequest.
interface nios2_oci_trace_capture_if #(
    parameter int AW = 7,
    parameter int DW = 34
);
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [DW-1:0] readdata;
    logic          readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/nios2_oci_trace_ram.sv
// nios2_oci_trace_ram: simple dual-port record store, registered read.
// A read colliding with a write to the same slot returns the old word.
module nios2_oci_trace_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // registered read port, sees pre-write contents
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/nios2_oci_trace_capture.sv
// nios2_oci_trace_capture: circular DCT record buffer with freeze control.
// Host dumps records oldest-first through the Avalon-MM slave port.
module nios2_oci_trace_capture
    import nios2_oci_trace_pkg::*;
#(
    parameter int DATA_W    = 30,
    parameter int CNT_W     = 4,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dct_valid,
    input  logic [DATA_W-1:0] dct_buffer,
    input  logic [CNT_W-1:0]  dct_count,
    input  logic              test_ending,
    input  logic              test_has_ended,
    nios2_oci_trace_capture_if.slave avs
);
    localparam int PW = $clog2(DEPTH);
    localparam int AW = PW + 1;
    localparam int RW = DATA_W + CNT_W;

    trace_state_e      state_q, state_d;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW:0]       entries_q;
    logic              wrapped_q;
    logic              mode_q;
    logic [DROP_W-1:0] drops_q;
    logic [PW:0]       post_cnt_q, post_cnt_d;
    logic              te_q;

    logic          te_rise, ctrl_wr, clear;
    logic          full, take, store, drop;
    logic          rd_mem, in_range;
    logic [PW-1:0] idx, oldest, rd_addr;
    logic [31:0]   status_w;
    logic [RW-1:0] ram_q, reg_q;
    logic          sel_mem_q, rvalid_q;
    logic          unused_wd;

    assign te_rise = test_ending & ~te_q;
    assign ctrl_wr = avs.write && (avs.address == AW'(REG_CONTROL));
    assign clear   = ctrl_wr && avs.writedata[CTRL_CLEAR_BIT];
    assign full    = (entries_q == (PW+1)'(DEPTH));
    assign take    = dct_valid && (state_q != ST_FROZEN)
                     && !test_has_ended && !clear;
    assign store   = take && (!mode_q || !full);
    assign drop    = take && mode_q && full;

    assign unused_wd = ^avs.writedata[31:2];

    // next state and post-trigger count
    always_comb begin
        state_d    = state_q;
        post_cnt_d = post_cnt_q;
        if (clear) begin
            state_d    = ST_CAPTURE;
            post_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_CAPTURE: begin
                    if (test_has_ended) begin
                        state_d = ST_FROZEN;
                    end else if (te_rise) begin
                        post_cnt_d = '0;
                        state_d = (POST_TRIG == 0) ? ST_FROZEN
                                                   : ST_POST;
                    end
                end
                ST_POST: begin
                    if (test_has_ended) begin
                        state_d = ST_FROZEN;
                    end else if (take) begin
                        if (post_cnt_q == (PW+1)'(POST_TRIG - 1))
                            state_d = ST_FROZEN;
                        else
                            post_cnt_d = post_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // state register and edge-detect history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_CAPTURE;
            post_cnt_q <= '0;
            te_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            post_cnt_q <= post_cnt_d;
            te_q       <= test_ending;
        end
    end

    // pointers, fill level, wrap flag, drop counter, mode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            entries_q <= '0;
            wrapped_q <= 1'b0;
            drops_q   <= '0;
            mode_q    <= 1'b0;
        end else if (clear) begin
            wr_ptr_q  <= '0;
            entries_q <= '0;
            wrapped_q <= 1'b0;
            drops_q   <= '0;
            mode_q    <= avs.writedata[CTRL_MODE_BIT];
        end else begin
            if (store) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (full) wrapped_q <= 1'b1;
                else      entries_q <= entries_q + 1'b1;
            end
            if (drop && (drops_q != '1))
                drops_q <= drops_q + 1'b1;
        end
    end

    assign rd_mem   = avs.address[AW-1];
    assign idx      = avs.address[PW-1:0];
    assign oldest   = wrapped_q ? wr_ptr_q : '0;
    assign rd_addr  = oldest + idx;
    assign in_range = ({1'b0, idx} < entries_q);
    assign status_w = pack_status(STAT_ENT_W'(entries_q), wrapped_q,
                                  mode_q, state_q, drops_q);

    nios2_oci_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_ram (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr_q),
        .wdata ({dct_count, dct_buffer}),
        .re    (avs.read && rd_mem),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // read response: register word or ram select, one-cycle latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q  <= 1'b0;
            sel_mem_q <= 1'b0;
            reg_q     <= '0;
        end else begin
            rvalid_q <= avs.read;
            if (avs.read) begin
                sel_mem_q <= rd_mem && in_range;
                if (!rd_mem && (avs.address == AW'(REG_STATUS)))
                    reg_q <= RW'(status_w);
                else
                    reg_q <= '0;
            end
        end
    end

    assign avs.readdata      = sel_mem_q ? ram_q : reg_q;
    assign avs.readdatavalid = rvalid_q;
endmodule
